// File: rtl/bsg_dff_en_rr_share_ctrl.sv
// bsg_dff_en_rr_share_ctrl: round-robin arbitration of els_p producers into one shared enable register
module bsg_dff_en_rr_share_ctrl #(
    parameter int els_p   = 4,
    parameter int width_p = 62,
    localparam int IDW    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*width_p-1:0] data_i,
    output logic [els_p-1:0]         yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic [IDW-1:0]           id_o,
    input  logic                     yumi_i
);
    logic               r_v;
    logic [IDW-1:0]     r_id;
    logic [IDW-1:0]     r_ptr;
    logic [width_p-1:0] r_data;
    logic               w_found;
    logic [IDW-1:0]     w_gid;
    logic               w_go;
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        for (int i = 0; i < els_p; i++) begin
            if (!w_found && v_i[(int'(r_ptr) + i) % els_p]) begin
                w_found = 1'b1;
                w_gid   = IDW'((int'(r_ptr) + i) % els_p);
            end
        end
    end
    // The slot is open when empty or when the consumer drains it this cycle.
    assign w_go   = (!r_v || yumi_i) && w_found && !reset_i;
    assign yumi_o = w_go ? (els_p'(1) << w_gid) : '0;
    assign v_o    = r_v;
    assign id_o   = r_id;
    assign data_o = r_data;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v   <= 1'b0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_go) begin
            r_v   <= 1'b1;
            r_id  <= w_gid;
            r_ptr <= (w_gid == IDW'(els_p - 1)) ? '0 : w_gid + 1'b1;
        end else if (yumi_i) begin
            r_v   <= 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (w_go) r_data <= data_i[w_gid*width_p +: width_p];
    end
    yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> r_v);
endmodule

// File: tb/tb_bsg_dff_en_rr_share_ctrl.sv
// tb_bsg_dff_en_rr_share_ctrl: directed scenarios plus random traffic against a scan-order reference model
module tb_bsg_dff_en_rr_share_ctrl;
    localparam int N = 4;
    localparam int W = 62;
    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   v_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     id_o;
    logic           yumi_i;
    int             compared = 0;
    int             mismatched = 0;
    int             m_ptr = 0;
    int             m_id = 0;
    bit             m_v = 1'b0;
    logic [W-1:0]   m_data = '0;
    logic [W-1:0]   words [N];

    always #5 clk = ~clk;

    bsg_dff_en_rr_share_ctrl #(.els_p(N), .width_p(W)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
        .v_o(v_o), .data_o(data_o), .id_o(id_o), .yumi_i(yumi_i)
    );

    // One cycle: drive inputs, check the grant, then check the held word after the edge.
    task automatic step(input logic [N-1:0] v, input bit y, input bit r);
        int g;
        logic [N-1:0] eg;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            words[k] = W'({$urandom, $urandom});
            data_i[k*W +: W] = words[k];
        end
        v_i     = v;
        yumi_i  = y & m_v;
        reset_i = r;
        g = -1;
        if (!r && (!m_v || yumi_i))
            for (int i = 0; i < N; i++)
                if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        eg = (g < 0) ? '0 : N'(1) << g;
        #1;
        compared++;
        assert (yumi_o === eg) else begin
            mismatched++;
            $error("FAIL yumi_o: got %b expected %b", yumi_o, eg);
        end
        @(posedge clk);
        if (r) begin
            m_v = 1'b0; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_v = 1'b1; m_data = words[g]; m_id = g; m_ptr = (g + 1) % N;
        end else if (yumi_i) begin
            m_v = 1'b0;
        end
        #1;
        compared++;
        assert (v_o === m_v) else begin
            mismatched++;
            $error("FAIL v_o: got %b expected %b", v_o, m_v);
        end
        if (m_v || r) begin
            compared++;
            assert (id_o === 2'(m_id)) else begin
                mismatched++;
                $error("FAIL id_o: got %0d expected %0d", id_o, m_id);
            end
        end
        if (m_v) begin
            compared++;
            assert (data_o === m_data) else begin
                mismatched++;
                $error("FAIL data_o: got %h expected %h", data_o, m_data);
            end
        end
    endtask

    initial begin
        reset_i = 1'b1; v_i = '0; yumi_i = 1'b0; data_i = '0;
        step(4'b1111, 0, 1);
        step(4'b1111, 0, 1);
        step(4'b1111, 0, 0);
        for (int i = 0; i < 6; i++) step(4'b1111, 1, 0);
        for (int i = 0; i < 5; i++) step(4'b0110, 0, 0);
        step(4'b0110, 1, 0);
        step(4'b0000, 1, 0);
        step(4'b0100, 0, 0);
        step(4'b0101, 1, 0);
        step(4'b0101, 1, 0);
        step(4'b0000, 1, 0);
        step(4'b0000, 0, 0);
        step(4'b0100, 0, 0);
        step(4'b1111, 0, 1);
        step(4'b1111, 0, 0);
        for (int i = 0; i < 400; i++)
            step(4'($urandom), 1'($urandom), $urandom_range(0, 49) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
